// File: rtl/pipe_ctrl_gen.sv
// Pipeline controller: merges stall requests, a multi-cycle hold FSM and a stage-targeted flush.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_gen #(
  parameter int NUM_STAGES = 6,
  parameter int NUM_REQ    = 4,
  parameter int MC_STAGE   = 3,
  parameter int MC_CNT_W   = 6,
  localparam int SIDX_W    = $clog2(NUM_STAGES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_all,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*SIDX_W-1:0] req_stage,
  input  logic                      mc_start,
  input  logic [MC_CNT_W-1:0]       mc_cycles,
  input  logic                      flush_req,
  input  logic [SIDX_W-1:0]         flush_stage,
  output logic [NUM_STAGES-1:0]     stall,
  output logic [NUM_STAGES-1:0]     flush,
  output logic                      mc_busy,
  output logic                      mc_done,
  output logic [31:0]               perf_stall,
  output logic [31:0]               perf_flush
);

  localparam logic [SIDX_W-1:0] MC_IDX = SIDX_W'(MC_STAGE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_reg, state_next;
  logic [MC_CNT_W-1:0]   cnt_reg, cnt_next;
  logic                  mc_hold;
  logic                  done_pulse;
  logic                  flush_acc;
  logic                  abort_flush;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] flush_raw;

  assign flush_acc   = flush_req & ~stall_all;
  assign abort_flush = flush_acc & (flush_stage > MC_IDX);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic req_hit;
      always_comb begin
        req_hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && (req_stage[i*SIDX_W +: SIDX_W] >= SIDX_W'(gi)))
            req_hit = 1'b1;
        end
      end
      assign flush_raw[gi] = flush_acc & (SIDX_W'(gi) < flush_stage);
      assign stall_raw[gi] = stall_all | req_hit | (mc_hold & (gi <= MC_STAGE));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Counter holds the number of BUSY cycles still to come after the current one,
  // so the start cycle plus BUSY cycles add up to mc_cycles-1 held cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mc_hold    = 1'b0;
    done_pulse = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mc_start && !stall_all && !abort_flush) begin
          if (mc_cycles >= MC_CNT_W'(3)) begin
            mc_hold    = 1'b1;
            cnt_next   = mc_cycles - MC_CNT_W'(3);
            state_next = BUSY;
          end else begin
            mc_hold    = (mc_cycles == MC_CNT_W'(2));
            state_next = DONE;
          end
        end
      end
      BUSY: begin
        if (abort_flush) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          mc_hold = 1'b1;
          if (!stall_all) begin
            if (cnt_reg == '0) state_next = DONE;
            else               cnt_next   = cnt_reg - MC_CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (abort_flush) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (!stall_all) begin
          done_pulse = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are gated by rst so the reset values appear without waiting for a clock edge.
  assign stall   = rst ? (stall_raw & ~flush_raw) : '1;
  assign flush   = rst ? flush_raw : '0;
  assign mc_busy = rst & (state_reg != IDLE);
  assign mc_done = rst & done_pulse;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if ((|stall) && (perf_stall_reg != 32'hFFFF_FFFF))
        perf_stall_reg <= perf_stall_reg + 32'd1;
      if ((|flush) && (perf_flush_reg != 32'hFFFF_FFFF))
        perf_flush_reg <= perf_flush_reg + 32'd1;
    end
  end

  assign perf_stall = perf_stall_reg;
  assign perf_flush = perf_flush_reg;
`else
  assign perf_stall = 32'd0;
  assign perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen: directed scenarios then random traffic vs a cycle-count model.
module tb_pipe_ctrl_gen;
  localparam int NS = 6;
  localparam int NR = 4;
  localparam int MC = 3;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_all;
  logic [NR-1:0] req_valid;
  logic [NR*SW-1:0] req_stage;
  logic          mc_start;
  logic [5:0]    mc_cycles;
  logic          flush_req;
  logic [SW-1:0] flush_stage;
  logic [NS-1:0] stall;
  logic [NS-1:0] flush;
  logic          mc_busy;
  logic          mc_done;
  logic [31:0]   perf_stall;
  logic [31:0]   perf_flush;

  pipe_ctrl_gen dut (
    .clk(clk), .rst(rst), .stall_all(stall_all), .req_valid(req_valid),
    .req_stage(req_stage), .mc_start(mc_start), .mc_cycles(mc_cycles),
    .flush_req(flush_req), .flush_stage(flush_stage), .stall(stall),
    .flush(flush), .mc_busy(mc_busy), .mc_done(mc_done),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] stall;
    logic [NS-1:0] flush;
    logic          busy;
    logic          done;
    logic [31:0]   ps;
    logic [31:0]   pf;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc_no = 0;
  int   done_seen = 0;

  // Reference model: an op is either absent, holding for hold_left more BUSY cycles, or in its done cycle.
  int   rs[NR];
  bit   m_active;
  int   m_hold_left;
  int   m_ps;
  int   m_pf;

  task automatic set_req_stage();
    for (int i = 0; i < NR; i++) req_stage[i*SW +: SW] = SW'(rs[i]);
  endtask

  task automatic step(input bit r, input bit sa, input logic [NR-1:0] rv, input bit ms,
                      input int cyc, input bit fr, input int fs);
    exp_t e;
    bit acc, abrt, start, hold, st, fl;
    @(posedge clk);
    #1;
    rst = r; stall_all = sa; req_valid = rv; mc_start = ms;
    mc_cycles = 6'(cyc); flush_req = fr; flush_stage = SW'(fs);
    if (!r) begin
      e.stall = '1; e.flush = '0; e.busy = 1'b0; e.done = 1'b0; e.ps = 0; e.pf = 0;
      m_active = 0; m_hold_left = 0; m_ps = 0; m_pf = 0;
    end else begin
      acc   = fr && !sa;
      abrt  = acc && (fs > MC);
      start = !m_active && ms && !sa && !abrt;
      hold  = (m_active && m_hold_left > 0) || (start && cyc >= 2);
      if (m_active && abrt) hold = 0;
      for (int k = 0; k < NS; k++) begin
        st = sa;
        for (int i = 0; i < NR; i++) if (rv[i] && rs[i] >= k) st = 1;
        if (hold && k <= MC) st = 1;
        fl = acc && (k < fs);
        if (fl) st = 0;
        e.stall[k] = st;
        e.flush[k] = fl;
      end
      e.busy = m_active;
      e.done = m_active && m_hold_left == 0 && !sa && !abrt;
`ifdef PIPE_CTRL_PERF_EN
      e.ps = m_ps; e.pf = m_pf;
`else
      e.ps = 0; e.pf = 0;
`endif
      if (|e.stall) m_ps++;
      if (|e.flush) m_pf++;
      if (!sa) begin
        if (m_active && abrt) m_active = 0;
        else if (m_active) begin
          if (m_hold_left > 0) m_hold_left--;
          else m_active = 0;
        end else if (start) begin
          m_active = 1;
          m_hold_left = (cyc >= 2) ? cyc - 2 : 0;
        end
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s cyc %0d: got %h expected %h", name, cyc_no, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc_no++;
        $display("cyc %0d stall=%b flush=%b busy=%b done=%b", cyc_no, stall, flush, mc_busy, mc_done);
        chk("stall", 32'(stall), 32'(e.stall));
        chk("flush", 32'(flush), 32'(e.flush));
        chk("mc_busy", 32'(mc_busy), 32'(e.busy));
        chk("mc_done", 32'(mc_done), 32'(e.done));
        chk("perf_stall", perf_stall, e.ps);
        chk("perf_flush", perf_flush, e.pf);
        if (mc_done) done_seen++;
      end
    end
  end

  initial begin : stim
    int ds;
    rst = 0; stall_all = 0; req_valid = '0; mc_start = 0; mc_cycles = '0;
    flush_req = 0; flush_stage = '0;
    rs[0] = 2; rs[1] = 5; rs[2] = 1; rs[3] = 0;
    set_req_stage();
    step(0, 0, '0, 0, 0, 0, 0);
    step(0, 0, 4'b0001, 1, 4, 1, 5);
    idle(2);
    // 1: single request at stage 2
    step(1, 0, 4'b0001, 0, 0, 0, 0);
    idle(1);
    // 2: four-cycle op
    step(1, 0, '0, 1, 4, 0, 0);
    step(1, 0, '0, 1, 4, 0, 0);
    idle(4);
    // 3: flush stage 3 with a request at stage 4
    step(0, 0, '0, 0, 0, 0, 0);
    rs[0] = 4; set_req_stage();
    step(1, 0, 4'b0001, 1, 0, 1, 3);
    idle(1);
    // 4: abort of an eight-cycle op on its second BUSY cycle
    ds = done_seen;
    step(1, 0, '0, 1, 8, 0, 0);
    step(1, 0, '0, 0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 1, 4);
    idle(10);
    // 5: stall_all for five cycles during BUSY
    step(1, 0, '0, 1, 4, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, '0, 0, 0, 1, 5);
    idle(5);
    // edge lengths, done-phase abort and start under abort-flush
    step(1, 0, '0, 1, 2, 0, 0);
    idle(3);
    step(1, 0, '0, 1, 1, 0, 0);
    idle(2);
    step(1, 0, '0, 1, 0, 0, 0);
    idle(2);
    step(1, 0, '0, 1, 3, 0, 0);
    step(1, 0, '0, 0, 0, 0, 0);
    step(1, 0, '0, 1, 5, 1, 6);
    step(1, 0, '0, 1, 5, 1, 4);
    idle(2);
    // 6: reset asserted mid-BUSY, request stages reassigned while in reset
    step(1, 0, '0, 1, 8, 0, 0);
    step(1, 0, '0, 0, 0, 0, 0);
    step(0, 0, 4'b1111, 1, 5, 1, 2);
    for (int i = 0; i < NR; i++) rs[i] = $urandom_range(0, NS - 1);
    set_req_stage();
    step(0, 0, '0, 0, 0, 0, 0);
    idle(2);
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0,
           ($urandom_range(0, 4) == 0),
           $urandom_range(0, 12),
           ($urandom_range(0, 7) == 0),
           $urandom_range(0, NS));
    end
    idle(2);
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    compared++;
    if (ds != 0 && done_seen == 0) begin
      mismatched++;
      $display("FAIL done_count: saw %0d done pulses, expected some", done_seen);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end
endmodule
